// File: rtl/bus32_epc_arbiter.sv
// Two-master round-robin arbiter and sequencer for one 32-bit EPC slave bus.
// A granted master performs a single strobed read or write with a per-access ready timeout.
module bus32_epc_arbiter #(
  parameter int datawidth      = 32,
  parameter int addrwidth      = 8,
  parameter int timeout_cycles = 64
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic                     m0_req_in,
  input  logic                     m0_wr_in,
  input  logic [addrwidth-1:0]     m0_addr_in,
  input  logic [datawidth-1:0]     m0_wdata_in,
  input  logic [datawidth/8-1:0]   m0_be_in,
  output logic                     m0_ack_out,
  output logic [datawidth-1:0]     m0_rdata_out,
  output logic                     m0_err_out,
  input  logic                     m1_req_in,
  input  logic                     m1_wr_in,
  input  logic [addrwidth-1:0]     m1_addr_in,
  input  logic [datawidth-1:0]     m1_wdata_in,
  input  logic [datawidth/8-1:0]   m1_be_in,
  output logic                     m1_ack_out,
  output logic [datawidth-1:0]     m1_rdata_out,
  output logic                     m1_err_out,
  output logic [addrwidth-1:0]     epc_addr_out,
  output logic [datawidth-1:0]     epc_data_out,
  output logic [datawidth/8-1:0]   epc_be_out,
  output logic                     epc_cs_n_out,
  output logic                     epc_wr_n_out,
  output logic                     epc_rd_n_out,
  input  logic [datawidth-1:0]     epc_data_in,
  input  logic                     epc_rdy_in,
  output logic                     busy_out,
  output logic [1:0]               grant_out,
  output logic                     timeout_pulse_out,
  output logic [1:0]               dbg_state_out
);

  localparam int BEW = datawidth / 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

  logic [1:0]           r_state;
  logic [15:0]          r_timer;
  logic                 r_wr;
  logic                 r_sel;
  logic                 r_last;
  logic [1:0]           r_grant;
  logic                 r_busy;
  logic [addrwidth-1:0] r_addr;
  logic [datawidth-1:0] r_data;
  logic [BEW-1:0]       r_be;
  logic                 r_cs_n;
  logic                 r_wr_n;
  logic                 r_rd_n;
  logic [datawidth-1:0] r_rdata;
  logic                 r_err;
  logic                 r_tmo;
  logic                 r_m0_ack;
  logic                 r_m0_err;
  logic [datawidth-1:0] r_m0_rdata;
  logic                 r_m1_ack;
  logic                 r_m1_err;
  logic [datawidth-1:0] r_m1_rdata;

  logic                 w_m0_req;
  logic                 w_m1_req;
  logic                 w_pick_m1;
  logic                 w_win;
  logic                 w_wr;
  logic [addrwidth-1:0] w_addr;
  logic [datawidth-1:0] w_data;
  logic [BEW-1:0]       w_be;

  // A master's req is still high during its own ack cycle; that stale level must not re-win.
  assign w_m0_req  = m0_req_in & ~r_m0_ack;
  assign w_m1_req  = m1_req_in & ~r_m1_ack;
  assign w_win     = w_m0_req | w_m1_req;
  // On a tie the master that was not served last wins (r_last: 1 = m1).
  assign w_pick_m1 = w_m1_req & (~w_m0_req | ~r_last);

  assign w_wr   = w_pick_m1 ? m1_wr_in    : m0_wr_in;
  assign w_addr = w_pick_m1 ? m1_addr_in  : m0_addr_in;
  assign w_data = w_pick_m1 ? m1_wdata_in : m0_wdata_in;
  assign w_be   = w_pick_m1 ? m1_be_in    : m0_be_in;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_wr       <= 1'b0;
      r_sel      <= 1'b0;
      r_last     <= 1'b1;
      r_grant    <= 2'b00;
      r_busy     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_be       <= '0;
      r_cs_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_tmo      <= 1'b0;
      r_m0_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_ack   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m1_rdata <= '0;
    end else begin
      r_m0_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_ack   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m1_rdata <= '0;
      r_tmo      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win) begin
            r_sel   <= w_pick_m1;
            r_grant <= w_pick_m1 ? 2'b10 : 2'b01;
            r_busy  <= 1'b1;
            r_wr    <= w_wr;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_be    <= w_be;
            r_timer <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cs_n  <= 1'b0;
            r_wr_n  <= ~w_wr;
            r_rd_n  <= w_wr;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Ready takes priority over a timeout falling on the same edge.
          if (epc_rdy_in) begin
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= r_wr ? ST_RESP : ST_CAPTURE;
          end else if (r_timer == TMO_LAST) begin
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= '1;
            r_tmo   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        ST_CAPTURE: begin
          r_rdata <= epc_data_in;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (r_sel) begin
            r_m1_ack   <= 1'b1;
            r_m1_rdata <= r_rdata;
            r_m1_err   <= r_err;
          end else begin
            r_m0_ack   <= 1'b1;
            r_m0_rdata <= r_rdata;
            r_m0_err   <= r_err;
          end
          r_last  <= r_sel;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_ack_out        = r_m0_ack;
  assign m0_rdata_out      = r_m0_rdata;
  assign m0_err_out        = r_m0_err;
  assign m1_ack_out        = r_m1_ack;
  assign m1_rdata_out      = r_m1_rdata;
  assign m1_err_out        = r_m1_err;
  assign epc_addr_out      = r_addr;
  assign epc_data_out      = r_data;
  assign epc_be_out        = r_be;
  assign epc_cs_n_out      = r_cs_n;
  assign epc_wr_n_out      = r_wr_n;
  assign epc_rd_n_out      = r_rd_n;
  assign busy_out          = r_busy;
  assign grant_out         = r_grant;
  assign timeout_pulse_out = r_tmo;
  assign dbg_state_out     = r_state;

endmodule

// File: tb/tb_bus32_epc_arbiter.sv
// Directed bench for bus32_epc_arbiter: main instance with timeout 64, a second
// instance with timeout 3 for the ready-versus-timeout tie.
module tb_bus32_epc_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Main instance signals
  logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [7:0]  m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [7:0]  epc_addr;
  logic [31:0] epc_wdata;
  logic [3:0]  epc_be;
  logic        epc_cs_n, epc_wr_n, epc_rd_n;
  logic [31:0] epc_rdata = '0;
  logic        epc_rdy;
  logic        busy, tmo_pulse;
  logic [1:0]  grant, dbg_state;

  // Slave model: ready after slave_wait strobe cycles (0 = never), read data registered on ready.
  int          slave_wait = 0;
  logic [31:0] slave_data = '0;
  int          s_cnt = 0;
  assign epc_rdy = (slave_wait != 0) && !epc_cs_n && (s_cnt == slave_wait - 1);
  always @(posedge clk) begin
    if (!epc_cs_n) s_cnt <= s_cnt + 1;
    else           s_cnt <= 0;
    if (epc_rdy && !epc_rd_n) epc_rdata <= slave_data;
  end

  bus32_epc_arbiter #(.datawidth(32), .addrwidth(8), .timeout_cycles(64)) u_dut (
    .clock_in(clk), .reset_n_in(rst_n),
    .m0_req_in(m0_req), .m0_wr_in(m0_wr), .m0_addr_in(m0_addr), .m0_wdata_in(m0_wdata),
    .m0_be_in(m0_be), .m0_ack_out(m0_ack), .m0_rdata_out(m0_rdata), .m0_err_out(m0_err),
    .m1_req_in(m1_req), .m1_wr_in(m1_wr), .m1_addr_in(m1_addr), .m1_wdata_in(m1_wdata),
    .m1_be_in(m1_be), .m1_ack_out(m1_ack), .m1_rdata_out(m1_rdata), .m1_err_out(m1_err),
    .epc_addr_out(epc_addr), .epc_data_out(epc_wdata), .epc_be_out(epc_be),
    .epc_cs_n_out(epc_cs_n), .epc_wr_n_out(epc_wr_n), .epc_rd_n_out(epc_rd_n),
    .epc_data_in(epc_rdata), .epc_rdy_in(epc_rdy),
    .busy_out(busy), .grant_out(grant), .timeout_pulse_out(tmo_pulse),
    .dbg_state_out(dbg_state)
  );

  // Timeout-3 instance signals (only master 0 used)
  logic        t3_m0_req = 0, t3_m1_req = 0, t3_wr = 0;
  logic [7:0]  t3_addr = 0;
  logic [31:0] t3_wdata = 0;
  logic [3:0]  t3_be = 0;
  logic        t3_m0_ack, t3_m0_err, t3_m1_ack, t3_m1_err;
  logic [31:0] t3_m0_rdata, t3_m1_rdata;
  logic [7:0]  t3_epc_addr;
  logic [31:0] t3_epc_wdata;
  logic [3:0]  t3_epc_be;
  logic        t3_cs_n, t3_wr_n, t3_rd_n;
  logic [31:0] t3_epc_rdata = '0;
  logic        t3_rdy;
  logic        t3_busy, t3_tmo;
  logic [1:0]  t3_grant, t3_dbg;

  int          t3_wait = 0;
  logic [31:0] t3_data = '0;
  int          t3_cnt = 0;
  assign t3_rdy = (t3_wait != 0) && !t3_cs_n && (t3_cnt == t3_wait - 1);
  always @(posedge clk) begin
    if (!t3_cs_n) t3_cnt <= t3_cnt + 1;
    else          t3_cnt <= 0;
    if (t3_rdy && !t3_rd_n) t3_epc_rdata <= t3_data;
  end

  bus32_epc_arbiter #(.datawidth(32), .addrwidth(8), .timeout_cycles(3)) u_dut_t3 (
    .clock_in(clk), .reset_n_in(rst_n),
    .m0_req_in(t3_m0_req), .m0_wr_in(t3_wr), .m0_addr_in(t3_addr), .m0_wdata_in(t3_wdata),
    .m0_be_in(t3_be), .m0_ack_out(t3_m0_ack), .m0_rdata_out(t3_m0_rdata), .m0_err_out(t3_m0_err),
    .m1_req_in(t3_m1_req), .m1_wr_in(t3_wr), .m1_addr_in(t3_addr), .m1_wdata_in(t3_wdata),
    .m1_be_in(t3_be), .m1_ack_out(t3_m1_ack), .m1_rdata_out(t3_m1_rdata), .m1_err_out(t3_m1_err),
    .epc_addr_out(t3_epc_addr), .epc_data_out(t3_epc_wdata), .epc_be_out(t3_epc_be),
    .epc_cs_n_out(t3_cs_n), .epc_wr_n_out(t3_wr_n), .epc_rd_n_out(t3_rd_n),
    .epc_data_in(t3_epc_rdata), .epc_rdy_in(t3_rdy),
    .busy_out(t3_busy), .grant_out(t3_grant), .timeout_pulse_out(t3_tmo),
    .dbg_state_out(t3_dbg)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({epc_cs_n, epc_wr_n, epc_rd_n} !== 3'b111) begin
      tests_failed++; $display("FAIL reset_strobes: got %b want 111", {epc_cs_n, epc_wr_n, epc_rd_n});
    end
    tests_run++;
    if ({epc_addr, epc_wdata, epc_be} !== 44'h0) begin
      tests_failed++; $display("FAIL reset_bus: got %h want 0", {epc_addr, epc_wdata, epc_be});
    end
    tests_run++;
    if ({m0_ack, m0_err, m1_ack, m1_err, tmo_pulse, busy} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 000000", {m0_ack, m0_err, m1_ack, m1_err, tmo_pulse, busy});
    end
    tests_run++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      tests_failed++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata});
    end
    tests_run++;
    if (grant !== 2'b00 || dbg_state !== 2'd0) begin
      tests_failed++; $display("FAIL reset_grant_state: got %b/%0d want 00/0", grant, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    int lat = 0, rd_low = 0, wr_low = 0;
    logic got = 0, err_at = 1;
    logic [31:0] rd_at = '0;
    slave_wait = 2; slave_data = 32'h5446_0001;
    m0_wr = 0; m0_addr = 8'h00; m0_req = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!epc_rd_n) rd_low++;
      if (!epc_wr_n) wr_low++;
      if (m0_ack) begin got = 1; lat = c; rd_at = m0_rdata; err_at = m0_err; break; end
    end
    m0_req = 0;
    tests_run++;
    if (!got || lat != 5) begin tests_failed++; $display("FAIL read_latency: got %0d want 5 (acked=%0d)", lat, got); end
    tests_run++;
    if (rd_at !== 32'h5446_0001 || err_at !== 1'b0) begin
      tests_failed++; $display("FAIL read_data: got %h err %b want 54460001 err 0", rd_at, err_at);
    end
    tests_run++;
    if (rd_low != 2 || wr_low != 0) begin
      tests_failed++; $display("FAIL read_strobes: got rd_low %0d wr_low %0d want 2/0", rd_low, wr_low);
    end
    @(negedge clk);
    tests_run++;
    if (m0_ack !== 1'b0 || m0_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL read_ack_width: got ack %b rdata %h want 0/0", m0_ack, m0_rdata);
    end
  endtask

  task automatic test_write();
    int lat = 0, rd_low = 0, wr_low = 0;
    logic got = 0, bus_ok = 1, err_at = 1;
    logic [31:0] rd_at = '1;
    logic [1:0]  grant_at = 2'b00;
    slave_wait = 1;
    m1_wr = 1; m1_addr = 8'h04; m1_wdata = 32'h0000_0003; m1_be = 4'hF; m1_req = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!epc_rd_n) rd_low++;
      if (!epc_wr_n) begin
        wr_low++;
        if (epc_addr !== 8'h04 || epc_wdata !== 32'h3 || epc_be !== 4'hF) bus_ok = 0;
      end
      if (m1_ack) begin got = 1; lat = c; rd_at = m1_rdata; err_at = m1_err; grant_at = grant; break; end
    end
    m1_req = 0;
    tests_run++;
    if (!got || lat != 3) begin tests_failed++; $display("FAIL write_latency: got %0d want 3 (acked=%0d)", lat, got); end
    tests_run++;
    if (wr_low != 1 || rd_low != 0 || !bus_ok) begin
      tests_failed++; $display("FAIL write_bus: got wr_low %0d rd_low %0d bus_ok %0d want 1/0/1", wr_low, rd_low, bus_ok);
    end
    tests_run++;
    if (rd_at !== 32'h0 || err_at !== 1'b0 || grant_at !== 2'b10) begin
      tests_failed++; $display("FAIL write_resp: got rdata %h err %b grant %b want 0/0/10", rd_at, err_at, grant_at);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] order [4];
    int n_grants = 0, acks0 = 0, acks1 = 0, hi_run = 0, min_gap = 99;
    logic prev_cs_n = 1, re0 = 0, re1 = 0;
    for (int i = 0; i < 4; i++) order[i] = 2'b00;
    slave_wait = 1;
    m0_wr = 1; m0_addr = 8'h10; m0_wdata = 32'h1111_0000; m0_be = 4'h3;
    m1_wr = 1; m1_addr = 8'h20; m1_wdata = 32'h2222_0000; m1_be = 4'hC;
    m0_req = 1; m1_req = 1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (re0) begin m0_req = 1; re0 = 0; end
      if (re1) begin m1_req = 1; re1 = 0; end
      if (!epc_cs_n && prev_cs_n) begin
        if (n_grants < 4) order[n_grants] = grant;
        if (n_grants > 0 && hi_run < min_gap) min_gap = hi_run;
        n_grants++;
      end
      if (epc_cs_n) hi_run++; else hi_run = 0;
      prev_cs_n = epc_cs_n;
      if (m0_ack) begin acks0++; m0_req = 0; if (acks0 < 2) re0 = 1; end
      if (m1_ack) begin acks1++; m1_req = 0; if (acks1 < 2) re1 = 1; end
      if (acks0 + acks1 >= 4) break;
    end
    m0_req = 0; m1_req = 0;
    tests_run++;
    if (acks0 != 2 || acks1 != 2 || n_grants != 4) begin
      tests_failed++; $display("FAIL b2b_counts: got acks %0d/%0d grants %0d want 2/2/4", acks0, acks1, n_grants);
    end
    tests_run++;
    if (order[0] !== 2'b01 || order[1] !== 2'b10 || order[2] !== 2'b01 || order[3] !== 2'b10) begin
      tests_failed++; $display("FAIL b2b_order: got %b %b %b %b want 01 10 01 10", order[0], order[1], order[2], order[3]);
    end
    tests_run++;
    if (min_gap < 2) begin tests_failed++; $display("FAIL b2b_gap: got %0d want >=2", min_gap); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat = 0, rd_low = 0, pulses = 0;
    logic got = 0, err_at = 0;
    logic [31:0] rd_at = '0;
    slave_wait = 0;
    m0_wr = 0; m0_addr = 8'h08; m0_req = 1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (!epc_rd_n) rd_low++;
      if (tmo_pulse) pulses++;
      if (m0_ack) begin got = 1; lat = c; rd_at = m0_rdata; err_at = m0_err; break; end
    end
    m0_req = 0;
    tests_run++;
    if (!got || lat != 66) begin tests_failed++; $display("FAIL tmo_latency: got %0d want 66 (acked=%0d)", lat, got); end
    tests_run++;
    if (rd_low != 64 || pulses != 1) begin
      tests_failed++; $display("FAIL tmo_strobes: got rd_low %0d pulses %0d want 64/1", rd_low, pulses);
    end
    tests_run++;
    if (err_at !== 1'b1 || rd_at !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL tmo_resp: got err %b rdata %h want 1/ffffffff", err_at, rd_at);
    end
    @(negedge clk);
    // Next access after an abort must complete normally.
    got = 0; lat = 0;
    slave_wait = 1; slave_data = 32'hA5A5_0F0F;
    m1_wr = 0; m1_addr = 8'h0C; m1_req = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (m1_ack) begin got = 1; lat = c; rd_at = m1_rdata; err_at = m1_err; break; end
    end
    m1_req = 0;
    tests_run++;
    if (!got || lat != 4 || rd_at !== 32'hA5A5_0F0F || err_at !== 1'b0) begin
      tests_failed++; $display("FAIL tmo_recover: got lat %0d rdata %h err %b want 4/a5a50f0f/0", lat, rd_at, err_at);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    logic got = 0, spurious = 0, first_seen = 0;
    logic [1:0] first_grant = 2'b00;
    logic [31:0] rd_at = '0;
    slave_wait = 0;
    m0_wr = 0; m0_addr = 8'h30; m0_req = 1;
    repeat (4) @(negedge clk);
    m1_wr = 0; m1_addr = 8'h34; m1_req = 1;
    rst_n = 0;
    #1;
    tests_run++;
    if (epc_cs_n !== 1'b1 || epc_rd_n !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++; $display("FAIL rstmid_async: got cs %b rd %b busy %b st %0d want 1/1/0/0", epc_cs_n, epc_rd_n, busy, dbg_state);
    end
    @(negedge clk);
    if (m0_ack || m1_ack) spurious = 1;
    rst_n = 1;
    slave_wait = 1; slave_data = 32'hC0DE_0005;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!epc_cs_n && !first_seen) begin first_seen = 1; first_grant = grant; end
      if (m1_ack) spurious = 1;
      if (m0_ack) begin got = 1; lat = c; rd_at = m0_rdata; break; end
    end
    m0_req = 0;
    tests_run++;
    if (spurious) begin tests_failed++; $display("FAIL rstmid_noack: got unexpected ack want none"); end
    tests_run++;
    if (first_grant !== 2'b01 || !got || lat != 4 || rd_at !== 32'hC0DE_0005) begin
      tests_failed++; $display("FAIL rstmid_reserve: got grant %b lat %0d rdata %h want 01/4/c0de0005", first_grant, lat, rd_at);
    end
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (m1_ack) begin got = 1; break; end
    end
    m1_req = 0;
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL rstmid_pending_m1: got no ack want ack"); end
    @(negedge clk);
  endtask

  task automatic test_rdy_timeout_tie();
    int lat = 0, rd_low = 0, pulses = 0;
    logic got = 0, err_at = 1;
    logic [31:0] rd_at = '0;
    t3_wait = 3; t3_data = 32'h1234_5678;
    t3_wr = 0; t3_addr = 8'h40; t3_m0_req = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!t3_rd_n) rd_low++;
      if (t3_tmo) pulses++;
      if (t3_m0_ack) begin got = 1; lat = c; rd_at = t3_m0_rdata; err_at = t3_m0_err; break; end
    end
    t3_m0_req = 0;
    tests_run++;
    if (!got || lat != 6 || rd_low != 3) begin
      tests_failed++; $display("FAIL tie_timing: got lat %0d rd_low %0d want 6/3", lat, rd_low);
    end
    tests_run++;
    if (err_at !== 1'b0 || rd_at !== 32'h1234_5678 || pulses != 0) begin
      tests_failed++; $display("FAIL tie_resp: got err %b rdata %h pulses %0d want 0/12345678/0", err_at, rd_at, pulses);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_rdy_timeout_tie();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
